// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with count, almost flags and overflow/underflow pulses.
// Define FIFO_FWFT_EN for first-word fall-through output; default is registered read data.
module param_sync_fifo #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 3,
    parameter int unsigned AFULL_TH  = 6,
    parameter int unsigned AEMPTY_TH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en,
    input  logic [DATA_W-1:0] din,
    input  logic              r_en,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned PTR_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              wr_acc;
    logic              rd_acc;

    // Status decoded from the registered pointers only.
    always_comb begin
        empty        = (wr_ptr == rd_ptr);
        full         = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                       (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
        count        = wr_ptr - rd_ptr;
        almost_empty = (count <= PTR_W'(AEMPTY_TH));
        almost_full  = (count >= PTR_W'(AFULL_TH));
        wr_acc       = w_en && !full;
        rd_acc       = r_en && !empty;
    end

    // Storage is not reset; writes in a reset cycle are dropped.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr[ADDR_W-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            overflow  <= w_en && full;
            underflow <= r_en && empty;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head entry falls through whenever data is present.
    always_comb begin
        dout = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];
    end
`else
    // Registered read data, updated only on an accepted read.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
        end else if (rd_acc) begin
            dout <= mem[rd_ptr[ADDR_W-1:0]];
        end
    end
`endif

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter DATA_W, default 8, width of each data word.
REQ-002 Parameter ADDR_W, default 3, address width; DEPTH = 2**ADDR_W entries (default 8).
REQ-003 Parameter AFULL_TH, default 6, almost_full asserts at count >= AFULL_TH.
REQ-004 Parameter AEMPTY_TH, default 2, almost_empty asserts at count <= AEMPTY_TH.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 w_en  input  1  write request.
REQ-008 din  input  DATA_W  write data.
REQ-009 r_en  input  1  read request.
REQ-010 dout  output  DATA_W  read data.
REQ-011 empty  output  1  FIFO holds 0 entries.
REQ-012 full  output  1  FIFO holds DEPTH entries.
REQ-013 almost_empty  output  1  count <= AEMPTY_TH.
REQ-014 almost_full  output  1  count >= AFULL_TH.
REQ-015 count  output  ADDR_W+1  current number of stored entries, 0..DEPTH.
REQ-016 overflow  output  1  one-cycle pulse: write refused.
REQ-017 underflow  output  1  one-cycle pulse: read refused.

Function
REQ-018 Write accepted iff w_en && !full; din stored at write pointer, write pointer +1.
REQ-019 Read accepted iff r_en && !empty; read pointer +1.
REQ-020 Pointers ADDR_W+1 bits, natural binary; low ADDR_W bits address storage; wrap from DEPTH-1 to 0 with MSB toggle.
REQ-021 full = (addresses equal, MSBs differ); empty = (pointers fully equal); both decoded from registered pointers, no lookahead.
REQ-022 count = wr_ptr - rd_ptr modulo 2**(ADDR_W+1); updates the cycle after an accepted operation.
REQ-023 Accepted write and accepted read in the same cycle: both performed, count unchanged.
REQ-024 Full + w_en + r_en: only read accepted; next cycle count = DEPTH-1, full low.
REQ-025 Empty + w_en + r_en: only write accepted; next cycle count = 1, empty low.
REQ-026 Refused writes and reads leave storage, pointers and count unchanged.
REQ-027 overflow registered high one cycle after a cycle with w_en && full; otherwise low.
REQ-028 underflow registered high one cycle after a cycle with r_en && empty; otherwise low.
REQ-029 almost_empty and almost_full are combinational decodes of count.
REQ-030 Standard mode: dout registered; loaded with head entry on accepted read, visible the cycle after; holds value otherwise.

Reset
REQ-031 rst high at a rising edge: pointers = 0, count = 0, dout = 0, overflow = 0, underflow = 0.
REQ-032 During and after reset: empty = 1, full = 0, almost_empty = 1, almost_full = 0 (default thresholds).
REQ-033 Reset takes priority over simultaneous w_en/r_en; accesses in a reset cycle are dropped, and a reset mid-stream discards all stored data.
REQ-034 Storage array is not reset.

Configuration
REQ-035 Macro FIFO_FWFT_EN defined: first-word fall-through; dout combinationally presents the head entry whenever !empty, reads as 0 when empty; accepted read advances to the next entry the following cycle.
REQ-036 FIFO_FWFT_EN undefined: standard mode per REQ-030, read latency 1 cycle.

Verification
REQ-037 Reset, then write 0x11..0x18 (8 writes) -> full=1 and count=8 after 8th edge; almost_full first high at count=6.
REQ-038 Full, 9th write 0xAA -> overflow pulses 1 cycle, count stays 8, later reads return 0x11..0x18 in order with no 0xAA.
REQ-039 Empty, r_en=1 -> underflow pulses 1 cycle, count stays 0, dout unchanged (standard) / 0 (FWFT).
REQ-040 Count=4, w_en=r_en=1 for 20 cycles with incrementing data -> count stays 4, data in order across pointer wrap.
REQ-041 Full, w_en=r_en=1 -> read only, count=7; empty, w_en=r_en=1 -> write only, count=1.
REQ-042 Count=5, rst pulsed one cycle with w_en=1 -> count=0, empty=1, dout=0, written word discarded.
